// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   state_t   : controller states (IDLE, RUN)
//   cnt_width : bit-counter width for a given operand width (minimum 1)
package serial_sub_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// half_sub : 1-bit half subtractor.
//   a, b  : operand bits (a - b)
//   diff  : difference bit
//   bout  : borrow out
// full_sub : 1-bit full subtractor built from two half_sub cells.
//   a, b  : operand bits (a - b - bin)
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module half_sub (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b;
   assign bout = ~a & b;

endmodule

module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   half_sub u_hs0 (
      .a    (a),
      .b    (b),
      .diff (d1),
      .bout (b1)
   );

   half_sub u_hs1 (
      .a    (d1),
      .b    (bin),
      .diff (diff),
      .bout (b2)
   );

   assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned subtractor (diff = a - b), LSB first,
// one full_sub cell time-shared over WIDTH cycles.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, sampled only while idle
//   a, b       : minuend / subtrahend, captured on the accepted start edge
//   busy       : high while an operation runs (exactly WIDTH cycles)
//   done       : one-cycle pulse when diff/borrow_out/zero are updated
//   diff       : a - b modulo 2^WIDTH, held until the next completion
//   borrow_out : 1 iff a < b, held with diff
//   zero       : 1 iff diff == 0, held with diff
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_next;
   logic             load;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             bor;
   logic             d;
   logic             nb;

   full_sub u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (bor),
      .diff (d),
      .bout (nb)
   );

   assign last = (cnt == CW'(WIDTH - 1));
   assign busy = (state == RUN);

   // Result shifts in at the MSB; written as shift-then-overwrite so that
   // WIDTH=1 needs no zero-width slice.
   always_comb begin
      res_next           = res_sh >> 1;
      res_next[WIDTH-1]  = d;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            if (last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         cnt        <= '0;
         bor        <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         zero       <= 1'b0;
      end else begin
         done <= (state == RUN) && last;
         if (load) begin
            a_sh <= a;
            b_sh <= b;
            bor  <= 1'b0;
            cnt  <= '0;
         end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            bor    <= nb;
            cnt    <= cnt + 1'b1;
            if (last) begin
               diff       <= res_next;
               borrow_out <= nb;
               zero       <= (res_next == '0);
            end
         end
      end
   end

endmodule
